fcbt_result_collector: RTL and testbench



---
 rtl/fcbt_result_collector_pkg.sv | 23 ++
 rtl/fcbt_result_collector_if.sv | 40 ++++
 rtl/fcbt_result_collector_fifo.sv | 63 ++++++
 rtl/fcbt_result_collector.sv | 109 ++++++++++
 tb/tb_fcbt_result_collector.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/fcbt_result_collector_pkg.sv
// Shared types and width helpers for the FCBT result collector.
package fcbt_collect_pkg;

   localparam int DEF_WIDTH           = 32;
   localparam int DEF_GROUP_ID_BITS   = 16;
   localparam int DEF_FIFO_DEPTH      = 8;
   localparam int DEF_MAX_OUTSTANDING = 16;

   // Width of a counter that must represent 0..max_value inclusive.
   function automatic int cnt_width(input int max_value);
      return $clog2(max_value + 1);
   endfunction

   localparam int DEF_PEND_W  = $clog2(DEF_MAX_OUTSTANDING + 1);
   localparam int DEF_COUNT_W = $clog2(DEF_FIFO_DEPTH + 1);

   // One buffered result at the default widths: the sum and the ID of its group.
   typedef struct packed {
      logic [DEF_WIDTH-1:0]         data;
      logic [DEF_GROUP_ID_BITS-1:0] group_id;
   } fcbt_result_t;

endpackage

// File: rtl/fcbt_result_collector_if.sv
// Bundle of accumulator-side, downstream-side and status signals of the collector.
interface fcbt_result_collector_if
   import fcbt_collect_pkg::*;
#(
   parameter int WIDTH           = DEF_WIDTH,
   parameter int GROUP_ID_BITS   = DEF_GROUP_ID_BITS,
   parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
);

   localparam int PEND_W = cnt_width(MAX_OUTSTANDING);

   logic                     acc_valid_out;
   logic [WIDTH-1:0]         acc_out;
   logic                     group_issued;
   logic [WIDTH-1:0]         out_data;
   logic [GROUP_ID_BITS-1:0] out_group_id;
   logic                     out_valid;
   logic                     out_ready;
   logic                     credit_ok;
   logic [PEND_W-1:0]        pending;
   logic                     idle;
   logic                     overflow;
   logic                     unexpected;
   logic                     clear_errors;

   // Environment side: source strobes, downstream ready, error clear.
   modport master (
      output acc_valid_out, acc_out, group_issued, out_ready, clear_errors,
      input  out_data, out_group_id, out_valid, credit_ok, pending, idle,
             overflow, unexpected
   );

   // Collector side.
   modport slave (
      input  acc_valid_out, acc_out, group_issued, out_ready, clear_errors,
      output out_data, out_group_id, out_valid, credit_ok, pending, idle,
             overflow, unexpected
   );

endinterface

// File: rtl/fcbt_result_collector_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is taken when a pop
// happens in the same cycle.
module fcbt_result_fifo
   import fcbt_collect_pkg::*;
#(
   parameter  int DATA_W  = 48,
   parameter  int DEPTH   = 8,
   localparam int PTR_W   = $clog2(DEPTH),
   localparam int COUNT_W = cnt_width(DEPTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic [DATA_W-1:0]  wr_data,
   input  logic               pop,
   output logic [DATA_W-1:0]  rd_data,
   output logic               full,
   output logic               empty,
   output logic [COUNT_W-1:0] count
);

   logic [DATA_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               do_push;
   logic               do_pop;

   assign empty   = (count == '0);
   assign full    = (count == COUNT_W'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Head entry is shown straight from the array; forced to zero when empty so
   // the output is defined after reset without clearing the storage.
   assign rd_data = empty ? '0 : mem[rd_ptr];

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // NOTE: non-blocking assignments everywhere in clocked blocks so every
         // register samples pre-edge values regardless of statement order.
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + COUNT_W'(1);
            2'b01:   count <= count - COUNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage write; full-with-pop writes the slot being vacated this cycle.
   // NOTE: the array has no reset; stale contents are never visible because
   // rd_data is qualified by empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/fcbt_result_collector.sv
// Collects accumulator group sums, tags them with a group ID, buffers them and
// tracks in-flight groups to grant credit back to the source.
module fcbt_result_collector
   import fcbt_collect_pkg::*;
#(
   parameter int WIDTH           = DEF_WIDTH,
   parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
   parameter int GROUP_ID_BITS   = DEF_GROUP_ID_BITS,
   parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
   input logic                   clk,
   input logic                   rst_n,
   fcbt_result_collector_if.slave bus
);

   localparam int PEND_W   = cnt_width(MAX_OUTSTANDING);
   localparam int COUNT_W  = cnt_width(FIFO_DEPTH);
   localparam int CREDIT_W = cnt_width(FIFO_DEPTH + MAX_OUTSTANDING);

   typedef struct packed {
      logic [WIDTH-1:0]         data;
      logic [GROUP_ID_BITS-1:0] group_id;
   } entry_t;

   entry_t                   wr_entry;
   entry_t                   rd_entry;
   logic [GROUP_ID_BITS-1:0] group_id_q;
   logic [PEND_W-1:0]        pending_q;
   logic                     overflow_q;
   logic                     unexpected_q;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic [COUNT_W-1:0]       fifo_count;
   logic                     pop;
   logic                     drop;
   logic                     pend_underflow;
   logic                     pend_overflow;
   logic [CREDIT_W-1:0]      committed;

   assign pop      = ~fifo_empty & bus.out_ready;
   assign wr_entry = '{data: bus.acc_out, group_id: group_id_q};

   fcbt_result_fifo #(
      .DATA_W ($bits(entry_t)),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (bus.acc_valid_out),
      .wr_data (wr_entry),
      .pop     (pop),
      .rd_data (rd_entry),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // A result is lost only when the FIFO is full and nothing leaves this cycle.
   assign drop = bus.acc_valid_out & fifo_full & ~pop;

   // A result with nothing outstanding is always suspicious, even if a group is
   // issued in the same cycle (the accumulator cannot turn a group around that
   // fast). Issue at the ceiling is only an error if no result frees a slot.
   assign pend_underflow = bus.acc_valid_out & (pending_q == '0);
   assign pend_overflow  = bus.group_issued & ~bus.acc_valid_out &
                           (pending_q == PEND_W'(MAX_OUTSTANDING));

   // Group ID counter: advances on every result, kept or dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 group_id_q <= '0;
      else if (bus.acc_valid_out) group_id_q <= group_id_q + GROUP_ID_BITS'(1);
   end

   // In-flight group counter, saturating at both ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
      end else if (bus.group_issued & ~bus.acc_valid_out & ~pend_overflow) begin
         pending_q <= pending_q + PEND_W'(1);
      end else if (bus.acc_valid_out & ~bus.group_issued & ~pend_underflow) begin
         pending_q <= pending_q - PEND_W'(1);
      end
   end

   // Sticky error flags; a new event in the clearing cycle keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q   <= 1'b0;
         unexpected_q <= 1'b0;
      end else begin
         overflow_q   <= (overflow_q & ~bus.clear_errors) | drop;
         unexpected_q <= (unexpected_q & ~bus.clear_errors) |
                         pend_underflow | pend_overflow;
      end
   end

   // Every slot already promised (buffered or in flight) counts against credit.
   assign committed = CREDIT_W'(fifo_count) + CREDIT_W'(pending_q);

   assign bus.out_data     = rd_entry.data;
   assign bus.out_group_id = rd_entry.group_id;
   assign bus.out_valid    = ~fifo_empty;
   assign bus.credit_ok    = committed < CREDIT_W'(FIFO_DEPTH);
   assign bus.pending      = pending_q;
   assign bus.idle         = (pending_q == '0) & fifo_empty;
   assign bus.overflow     = overflow_q;
   assign bus.unexpected   = unexpected_q;

endmodule

// File: tb/tb_fcbt_result_collector.sv
// Self-checking bench for fcbt_result_collector: directed scenarios plus random
// traffic compared against a queue-based model of the collector's behaviour.
module tb_fcbt_result_collector;
   import fcbt_collect_pkg::*;

   localparam int WIDTH = 32;
   localparam int DEPTH = 8;
   localparam int GIB   = 16;
   localparam int MAXO  = 16;
   localparam int GIB4  = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fcbt_result_collector_if #(.WIDTH(WIDTH), .GROUP_ID_BITS(GIB),  .MAX_OUTSTANDING(MAXO)) bus  ();
   fcbt_result_collector_if #(.WIDTH(WIDTH), .GROUP_ID_BITS(GIB4), .MAX_OUTSTANDING(MAXO)) bus4 ();

   fcbt_result_collector #(
      .WIDTH(WIDTH), .FIFO_DEPTH(DEPTH), .GROUP_ID_BITS(GIB), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   fcbt_result_collector #(
      .WIDTH(WIDTH), .FIFO_DEPTH(DEPTH), .GROUP_ID_BITS(GIB4), .MAX_OUTSTANDING(MAXO)
   ) dut4 (
      .clk(clk), .rst_n(rst_n), .bus(bus4)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state.
   fcbt_result_t mq[$];
   int           m_id;
   int           m_pend;
   bit           m_ovf;
   bit           m_unx;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_id   = 0;
      m_pend = 0;
      m_ovf  = 1'b0;
      m_unx  = 1'b0;
   endtask

   task automatic drive(input bit av, input logic [31:0] d, input bit gi,
                        input bit rdy, input bit clr);
      bus.acc_valid_out = av;
      bus.acc_out       = d;
      bus.group_issued  = gi;
      bus.out_ready     = rdy;
      bus.clear_errors  = clr;
   endtask

   // Apply one clock of the collector's rules to the model.
   task automatic model_cycle();
      bit pop_now, keep, ovf_ev, unx_ev;
      pop_now = (mq.size() > 0) && bus.out_ready;
      keep    = bus.acc_valid_out && ((mq.size() < DEPTH) || pop_now);
      ovf_ev  = bus.acc_valid_out && !keep;
      unx_ev  = (bus.acc_valid_out && m_pend == 0) ||
                (bus.group_issued && !bus.acc_valid_out && m_pend == MAXO);
      if (pop_now) void'(mq.pop_front());
      if (keep) mq.push_back('{data: bus.acc_out, group_id: GIB'(m_id)});
      if (bus.acc_valid_out) m_id = (m_id + 1) % (1 << GIB);
      if (bus.group_issued && !bus.acc_valid_out)      m_pend = (m_pend < MAXO) ? m_pend + 1 : MAXO;
      else if (bus.acc_valid_out && !bus.group_issued) m_pend = (m_pend > 0) ? m_pend - 1 : 0;
      m_ovf = (m_ovf && !bus.clear_errors) || ovf_ev;
      m_unx = (m_unx && !bus.clear_errors) || unx_ev;
   endtask

   task automatic compare_all(input string tag);
      check($sformatf("%s.valid", tag), 64'(bus.out_valid), 64'(mq.size() > 0));
      if (mq.size() > 0) begin
         check($sformatf("%s.data", tag), 64'(bus.out_data), 64'(mq[0].data));
         check($sformatf("%s.id", tag),   64'(bus.out_group_id), 64'(mq[0].group_id));
      end
      check($sformatf("%s.pending", tag), 64'(bus.pending), 64'(m_pend));
      check($sformatf("%s.idle", tag),    64'(bus.idle), 64'(m_pend == 0 && mq.size() == 0));
      check($sformatf("%s.credit", tag),  64'(bus.credit_ok), 64'((mq.size() + m_pend) < DEPTH));
      check($sformatf("%s.ovf", tag),     64'(bus.overflow), 64'(m_ovf));
      check($sformatf("%s.unx", tag),     64'(bus.unexpected), 64'(m_unx));
   endtask

   // Drive one cycle of inputs, advance model and DUT, compare after the edge.
   task automatic cyc(input bit av, input logic [31:0] d, input bit gi,
                      input bit rdy, input bit clr, input string tag);
      drive(av, d, gi, rdy, clr);
      model_cycle();
      @(posedge clk);
      #1;
      compare_all(tag);
   endtask

   // Asynchronous reset: outputs must clear before any clock edge.
   task automatic do_reset(input string tag);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      bus4.acc_valid_out = 1'b0;
      bus4.group_issued  = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check($sformatf("%s.rst_valid", tag),  64'(bus.out_valid), 64'(0));
      check($sformatf("%s.rst_data", tag),   64'(bus.out_data), 64'(0));
      check($sformatf("%s.rst_id", tag),     64'(bus.out_group_id), 64'(0));
      check($sformatf("%s.rst_pending", tag),64'(bus.pending), 64'(0));
      check($sformatf("%s.rst_idle", tag),   64'(bus.idle), 64'(1));
      check($sformatf("%s.rst_credit", tag), 64'(bus.credit_ok), 64'(1));
      check($sformatf("%s.rst_flags", tag),  64'({bus.overflow, bus.unexpected}), 64'(0));
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      bus4.acc_valid_out = 1'b0;
      bus4.acc_out       = '0;
      bus4.group_issued  = 1'b0;
      bus4.out_ready     = 1'b1;
      bus4.clear_errors  = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      do_reset("init");

      // Three groups, then results A/B/C streamed straight through.
      for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, "t1_issue");
      cyc(1'b1, 32'hA, 1'b0, 1'b1, 1'b0, "t1_a");
      check("t1_a_id", 64'(bus.out_group_id), 64'(0));
      cyc(1'b1, 32'hB, 1'b0, 1'b1, 1'b0, "t1_b");
      check("t1_b_id", 64'(bus.out_group_id), 64'(1));
      cyc(1'b1, 32'hC, 1'b0, 1'b1, 1'b0, "t1_c");
      check("t1_c_data", 64'(bus.out_data), 64'(32'hC));
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, "t1_drain");
      check("t1_idle", 64'(bus.idle), 64'(1));

      // Nine results into a stalled FIFO: the ninth is dropped.
      do_reset("t2");
      for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, "t2_issue");
      for (int i = 0; i < 9; i++) cyc(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0, "t2_fill");
      check("t2_overflow", 64'(bus.overflow), 64'(1));
      for (int i = 0; i < 8; i++) begin
         check("t2_drain_id", 64'(bus.out_group_id), 64'(i));
         cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, "t2_drain");
      end
      cyc(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, "t2_next");
      check("t2_next_id", 64'(bus.out_group_id), 64'(9));

      // Full FIFO with simultaneous push and pop.
      do_reset("t3");
      for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, "t3_issue");
      for (int i = 0; i < 8; i++) cyc(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0, 1'b0, "t3_fill");
      cyc(1'b1, 32'h3FF, 1'b0, 1'b1, 1'b0, "t3_pushpop");
      check("t3_no_ovf", 64'(bus.overflow), 64'(0));
      for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, "t3_drain");

      // Credit: pending 5 + buffered 3 exhausts an 8-deep FIFO.
      do_reset("t4");
      for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, "t4_issue");
      for (int i = 0; i < 3; i++) cyc(1'b1, 32'h400 + 32'(i), 1'b0, 1'b0, 1'b0, "t4_fill");
      check("t4_pending5", 64'(bus.pending), 64'(5));
      check("t4_credit_lo", 64'(bus.credit_ok), 64'(0));
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, "t4_pop");
      check("t4_credit_hi", 64'(bus.credit_ok), 64'(1));

      // Result with nothing in flight, then clear.
      do_reset("t5");
      cyc(1'b1, 32'h55, 1'b0, 1'b0, 1'b0, "t5_stray");
      check("t5_unexpected", 64'(bus.unexpected), 64'(1));
      check("t5_pending0", 64'(bus.pending), 64'(0));
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, "t5_clear");
      check("t5_cleared", 64'(bus.unexpected), 64'(0));

      // Reset with four entries buffered; IDs restart at zero.
      do_reset("t6");
      for (int i = 0; i < 6; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, "t6_issue");
      for (int i = 0; i < 4; i++) cyc(1'b1, 32'h600 + 32'(i), 1'b0, 1'b0, 1'b0, "t6_fill");
      do_reset("t6_mid");
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, "t6_reissue");
      cyc(1'b1, 32'h6AA, 1'b0, 1'b0, 1'b0, "t6_after");
      check("t6_restart_id", 64'(bus.out_group_id), 64'(0));

      // Random traffic against the model.
      do_reset("rnd");
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom_range(0, 2) == 0), $urandom(), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0), "rnd");
      end

      // 4-bit group ID wraps 15 -> 0 on the 17th result.
      do_reset("wrap");
      drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 17; i++) begin
         bus4.group_issued  = 1'b1;
         bus4.acc_valid_out = 1'b0;
         @(posedge clk);
         #1;
         bus4.group_issued  = 1'b0;
         bus4.acc_valid_out = 1'b1;
         bus4.acc_out       = 32'h700 + 32'(i);
         @(posedge clk);
         #1;
         bus4.acc_valid_out = 1'b0;
         check("wrap_valid", 64'(bus4.out_valid), 64'(1));
         check("wrap_id", 64'(bus4.out_group_id), 64'(i % 16));
      end
      check("wrap_unexpected", 64'(bus4.unexpected), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
